// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed operation is enabled by defining DIV_SIGNED_EN; the default build divides unsigned.
package div_pkg;

   localparam int DIV_W = 32;

   // Width of a counter that can hold the values 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int CNT_W = cnt_w(DIV_W);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      ITER,
      FIX
   } state_t;

endpackage

// File: rtl/seq_divider32_if.sv
// Request/result bundle between the arithmetic unit and the sequential divider.
interface seq_divider32_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, a, b,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             d_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // One extra bit so the shifted remainder (up to 2*divisor-1) compares without overflow.
   logic [WIDTH:0] r_sh;

   always_comb begin
      r_sh    = {rem_in, d_msb};
      q_bit   = (r_sh >= {1'b0, divisor});
      rem_out = q_bit ? WIDTH'(r_sh - {1'b0, divisor}) : r_sh[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle radix-2 restoring divider, WIDTH+2 cycles per operation.
// Define DIV_SIGNED_EN for two's-complement signed division; otherwise operands are unsigned.
module seq_divider32
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic           clk,
   input  logic           reset,
   seq_divider32_if.slave bus
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nxt;
   logic             busy_r, done_r, dz_r;
   logic [WIDTH-1:0] quot_r, rem_r;
   logic [WIDTH-1:0] a_r, b_r, dq, r;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] r_step;
   logic             q_bit;
   logic             accept;
`ifdef DIV_SIGNED_EN
   logic             qs, rs;
`endif

   assign accept = (state == IDLE) && bus.start && !busy_r;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (r),
      .d_msb   (dq[WIDTH-1]),
      .divisor (b_r),
      .rem_out (r_step),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = PREP;
         PREP:    state_nxt = (b_r == '0) ? FIX : ITER;
         ITER:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: only the visible status/result registers are reset; the datapath below is always
   // rewritten by the PREP state before it is read, so it carries no reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
         quot_r <= '0;
         rem_r  <= '0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            busy_r <= 1'b1;
            dz_r   <= 1'b0;
         end
         if (state == FIX) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dz_r   <= (b_r == '0);
            if (b_r == '0) begin
               quot_r <= '1;
               rem_r  <= a_r;
            end else begin
`ifdef DIV_SIGNED_EN
               quot_r <= qs ? -dq : dq;
               rem_r  <= rs ? -r : r;
`else
               quot_r <= dq;
               rem_r  <= r;
`endif
            end
         end
      end
   end

   // dq holds the dividend and fills with quotient bits from the bottom as the dividend shifts out.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (accept) begin
               a_r <= bus.a;
               b_r <= bus.b;
            end
         end
         PREP: begin
`ifdef DIV_SIGNED_EN
            dq  <= a_r[WIDTH-1] ? -a_r : a_r;
            b_r <= b_r[WIDTH-1] ? -b_r : b_r;
            qs  <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
            rs  <= a_r[WIDTH-1];
`else
            dq  <= a_r;
`endif
            r   <= '0;
            cnt <= '0;
         end
         ITER: begin
            dq  <= {dq[WIDTH-2:0], q_bit};
            r   <= r_step;
            cnt <= cnt + CW'(1);
         end
         default: ;
      endcase
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quot_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32; expected values are hand-computed.
// Vectors follow the build: DIV_SIGNED_EN selects the signed expectations.
module tb_seq_divider32;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_divider32_if #(.WIDTH(32)) bus ();

   seq_divider32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request and waits for done; called 1 time unit after a rising edge.
   // glitch_at >= 0 pulses a second start that many edges into the operation.
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_lat, input int glitch_at);
      int   lat;
      logic busy_ok;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat       = 0;
      busy_ok   = bus.busy;
      while (!bus.done && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (!bus.done && !bus.busy) busy_ok = 1'b0;
         if (lat == glitch_at) begin
            bus.a     = 32'd77;
            bus.b     = 32'd7;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " quotient"}, bus.quotient, exp_q);
      check({tag, " remainder"}, bus.remainder, exp_r);
      check({tag, " div_by_zero"}, bus.div_by_zero, exp_dz);
      check({tag, " busy held"}, busy_ok, 1'b1);
      check({tag, " busy at done"}, bus.busy, 1'b0);
   endtask

   initial begin
      int   saw_done;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      check("reset quotient", bus.quotient, 32'd0);
      check("reset remainder", bus.remainder, 32'd0);
      check("reset div_by_zero", bus.div_by_zero, 1'b0);
      reset = 1'b0;

      do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, -1);
      @(posedge clk);
      #1;
      check("done one cycle", bus.done, 1'b0);
      check("quotient hold", bus.quotient, 32'd14);

`ifdef DIV_SIGNED_EN
      do_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, -1);
      do_div("minneg/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, -1);
      do_div("minneg/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 34, -1);
      do_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, -1);
`else
      do_div("0xFFFFFF9C/7", 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 34, -1);
      do_div("0x80000000/max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, -1);
      do_div("0x80000000/2", 32'h8000_0000, 32'd2, 32'h4000_0000, 32'd0, 1'b0, 34, -1);
      do_div("7/0xFFFFFFFE", 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 34, -1);
`endif
      // All-ones / 1 gives the same bits in both builds.
      do_div("ones/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, -1);

      do_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, -1);
      @(posedge clk);
      #1;
      check("div_by_zero hold", bus.div_by_zero, 1'b1);
      do_div("6/3", 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 34, -1);

      // Abort in the middle of the iteration phase.
      bus.a     = 32'd12345;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort busy", bus.busy, 1'b0);
      check("abort done", bus.done, 1'b0);
      check("abort quotient", bus.quotient, 32'd0);
      check("abort remainder", bus.remainder, 32'd0);
      reset    = 1'b0;
      saw_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) saw_done++;
      end
      check("abort no done", saw_done, 0);
      do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, -1);

      // Start while busy is ignored; start in the done cycle is taken.
      do_div("1000/10 glitch", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34, 5);
      do_div("200/9 back2back", 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 34, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
